// File: rtl/pwm_decoder.sv
// PWM receiver: measures each period between rising edges of pwm_signal
// and recovers the duty code, with error and stuck-line flags.
//
// Ports:
//   clk_3125KHz  sole clock
//   rst_n        synchronous active-low reset
//   pwm_signal   asynchronous PWM input line
//   duty_cycle   last recovered duty code (high cycles per period)
//   duty_valid   one-cycle strobe when duty_cycle updates
//   period_err   one-cycle strobe on a short or overlong period
//   stuck_high   line held high for PERIOD or more cycles
//
// Optional: define PWM_DEC_GLITCH_FILTER_EN to add a 2-cycle stability
// filter after the synchronizer (rejects single-cycle glitches).
module pwm_decoder #(
  parameter int PERIOD = 16,
  parameter int DUTY_W = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clk_3125KHz,
  input  logic              rst_n,
  input  logic              pwm_signal,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              duty_valid,
  output logic              period_err,
  output logic              stuck_high
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] PER = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] PER_M1 = CNT_W'(PERIOD - 1);

  logic sync1, sync2;
  logic pwm_s, pwm_d;
  logic rise, chg, hit;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  period_cnt, period_nx;
  logic [DUTY_W-1:0] high_cnt, high_nx;
  logic [CNT_W-1:0]  lvl_cnt, lvl_nx;
  logic [DUTY_W-1:0] duty_nx;
  logic              valid_nx, err_nx, stuck_nx;
  logic              low_win;

  always_ff @(posedge clk_3125KHz) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_signal;
      sync2 <= sync1;
    end
  end

`ifdef PWM_DEC_GLITCH_FILTER_EN
  logic sync3, filt;

  // Follow the synchronizer only once it has held a value 2 cycles.
  always_ff @(posedge clk_3125KHz) begin
    if (!rst_n) begin
      sync3 <= 1'b0;
      filt  <= 1'b0;
    end else begin
      sync3 <= sync2;
      if (sync2 == sync3) filt <= sync2;
    end
  end

  assign pwm_s = filt;
`else
  assign pwm_s = sync2;
`endif

  assign rise = pwm_s & ~pwm_d;
  assign chg  = pwm_s ^ pwm_d;
  // Level run reaches PERIOD cycles on this edge (or already sits there).
  assign hit  = ~chg & (lvl_cnt >= PER_M1);

  always_comb begin
    state_nx  = state;
    period_nx = period_cnt;
    high_nx   = high_cnt;
    duty_nx   = duty_cycle;
    valid_nx  = 1'b0;
    err_nx    = 1'b0;
    stuck_nx  = stuck_high;
    low_win   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          period_nx = CNT_W'(1);
          high_nx   = DUTY_W'(1);
          state_nx  = MEASURE;
        end else if (hit) begin
          if (!pwm_s) begin
            duty_nx  = '0;
            valid_nx = 1'b1;
            low_win  = 1'b1;
          end else begin
            stuck_nx = 1'b1;
          end
        end
      end
      MEASURE: begin
        if (rise) begin
          if (period_cnt == PER) begin
            duty_nx  = high_cnt;
            valid_nx = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
          period_nx = CNT_W'(1);
          high_nx   = DUTY_W'(1);
        end else if (period_cnt == PER) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          period_nx = period_cnt + CNT_W'(1);
          high_nx   = high_cnt + DUTY_W'(pwm_s);
        end
      end
      default: state_nx = IDLE;
    endcase
    if (valid_nx || err_nx) stuck_nx = 1'b0;
  end

  always_comb begin
    lvl_nx = lvl_cnt;
    if (chg) begin
      lvl_nx = CNT_W'(1);
    end else if (low_win) begin
      lvl_nx = '0;
    end else if (lvl_cnt != PER) begin
      lvl_nx = lvl_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_3125KHz) begin
    if (!rst_n) begin
      pwm_d      <= 1'b0;
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      lvl_cnt    <= '0;
      duty_cycle <= '0;
      duty_valid <= 1'b0;
      period_err <= 1'b0;
      stuck_high <= 1'b0;
    end else begin
      pwm_d      <= pwm_s;
      state      <= state_nx;
      period_cnt <= period_nx;
      high_cnt   <= high_nx;
      lvl_cnt    <= lvl_nx;
      duty_cycle <= duty_nx;
      duty_valid <= valid_nx;
      period_err <= err_nx;
      stuck_high <= stuck_nx;
    end
  end

endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
Receive-side counterpart of the team's PWM generator. It samples an incoming PWM line in the clk_3125KHz domain, measures each period between rising edges, and recovers the 4-bit duty-cycle code. Results go out as a one-cycle valid strobe, with error and stuck-line flags. Used for loopback checking of the generator and for decoding external PWM commands.

Parameters:
PERIOD, 16, expected PWM period in clk_3125KHz cycles (generator: 16 cycles, 195 kHz)
DUTY_W, 4, width of recovered duty_cycle; must satisfy 2**DUTY_W >= PERIOD
CNT_W, 5, counter width; must satisfy 2**CNT_W > PERIOD

Ports:
clk_3125KHz  input  1  sole clock, 3.125 MHz
rst_n  input  1  synchronous reset, active-low
pwm_signal  input  1  PWM line, asynchronous to clk_3125KHz
duty_cycle  output  DUTY_W  last recovered duty code (high cycles per period)
duty_valid  output  1  one-cycle pulse when duty_cycle is updated
period_err  output  1  one-cycle pulse on a short or overlong period
stuck_high  output  1  level flag: line held high for >= PERIOD consecutive cycles

Behaviour:
- Clocking and reset: one clock, clk_3125KHz. rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clock edge): sync flops=0, pwm_d=0, state=IDLE, all counters=0, duty_cycle=0, duty_valid=0, period_err=0, stuck_high=0. A reset mid-period discards that period; no strobe is issued for it.
- Input path: 2-flop synchronizer gives pwm_s, then pwm_d = pwm_s delayed 1 cycle. rise = pwm_s & ~pwm_d.
- Level counter lvl_cnt (CNT_W): counts consecutive cycles with unchanged pwm_s, resets to 1 on any change, saturates at PERIOD.
- FSM states: IDLE, MEASURE.
- IDLE:
  - On rise: period_cnt<=1, high_cnt<=1, go to MEASURE. No output for this first, partial period.
  - If pwm_s=0 and lvl_cnt reaches PERIOD: duty_cycle<=0, duty_valid pulse, lvl_cnt<=0. This repeats every PERIOD cycles while the line stays low (0% duty).
  - If pwm_s=1 and lvl_cnt reaches PERIOD: stuck_high<=1.
- MEASURE, per cycle without rise: period_cnt+=1, high_cnt+=pwm_s.
- MEASURE, on rise:
  - If period_cnt==PERIOD: duty_cycle<=high_cnt[DUTY_W-1:0] and duty_valid pulses the next cycle.
  - Else (short period): period_err pulses and duty_cycle holds.
  - In both cases period_cnt<=1, high_cnt<=1, stay in MEASURE.
- MEASURE overflow: period_cnt==PERIOD and no rise this cycle -> period_err pulse, go to IDLE, lvl_cnt continues counting.
- Valid range: a period closed by a rise always contains at least one low cycle, so high_cnt <= PERIOD-1 and fits DUTY_W bits; no truncation occurs.
- stuck_high: cleared on the next duty_valid or period_err, or on reset.
- Simultaneous events: rise with overflow cannot occur, because a rise closes the period first. A duty_valid from the IDLE low-window and a rise in the same cycle: the rise takes priority and no low-window strobe is issued.
- Latency: a pwm_signal edge reaches pwm_s after 2 cycles; duty_valid asserts 1 cycle after the closing rise, i.e. 3-4 cycles after the external edge.
- Outputs are registered; duty_valid and period_err are never high together.

Optional Feature:
PWM_DEC_GLITCH_FILTER_EN
- Defined: a 2-cycle stability filter follows the synchronizer. pwm_s changes only after the synchronized input holds its new value for 2 consecutive cycles. Single-cycle glitches are rejected. Latency grows by 2 cycles. A true 1-cycle high pulse decodes as 0% duty.
- Undefined: pwm_s is taken directly from the synchronizer, and every 1-cycle pulse counts.

Test Plan:
- Generator loopback, duty code 5, 20 periods -> after the first full period, duty_valid once every 16 cycles with duty_cycle=5; period_err never asserted.
- Line held low from reset for 64 cycles -> duty_valid with duty_cycle=0 four times, 16 cycles apart; stuck_high=0.
- Sweep duty code 1..15, 3 periods each -> each code appears on duty_cycle within 2 periods of the change; 15 gives 15 high cycles per 16.
- Rises spaced 12 cycles apart -> period_err pulse per period; duty_cycle holds its prior value.
- Valid duty 7, then line forced high for 40 cycles -> period_err at overflow, stuck_high=1 by 16 cycles later; clears on the next valid period.
- rst_n=0 for 1 cycle mid-period at duty 9 -> all outputs 0 next cycle; first duty_valid comes only after one discarded partial period plus one full 16-cycle period, value 9.
